// File: rtl/rf_wb_sched.sv
// rf_wb_sched
//   Register-file write-port scheduler. The single RF write port is shared
//   between the core writeback path (primary) and a buffered long-latency
//   result source (secondary). Secondary results sit in a small FIFO and
//   drain into cycles where the primary does not write. A primary write
//   kills any queued secondary result for the same register. If the FIFO
//   head keeps losing the port, core_stall forces a drain cycle.
//
// Parameters
//   DEPTH         secondary FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  lost cycles tolerated before core_stall (>= 1)
//
// Ports
//   cpu_clk     core clock, rising edge
//   cpu_rst     synchronous active-high reset
//   p_we/p_wR/p_wD   primary write request
//   s_valid/s_ready  secondary handshake; s_wR/s_wD secondary payload
//   rf_we/rf_wR/rf_wD  granted RF write
//   busy_mask   registers with a valid queued secondary write
//   core_stall  core must freeze for a forced drain cycle
module rf_wb_sched #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        p_we,
  input  logic [4:0]  p_wR,
  input  logic [31:0] p_wD,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_wR,
  input  logic [31:0] s_wD,
  output logic        rf_we,
  output logic [4:0]  rf_wR,
  output logic [31:0] rf_wD,
  output logic [31:0] busy_mask,
  output logic        core_stall
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  logic          ent_valid [DEPTH];
  logic [4:0]    ent_wr    [DEPTH];
  logic [31:0]   ent_wd    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SCW-1:0] sc;

  logic empty;
  logic head_valid;
  logic pw;
  logic grant_head;
  logic pop;
  logic push;
  logic push_valid;

  assign empty      = (count == '0);
  assign head_valid = !empty && ent_valid[rd_ptr];
  assign core_stall = (sc >= SCW'(STARVE_LIMIT));
  assign s_ready    = (count != CW'(DEPTH));

  // A forced stall takes the port away from the primary so the head drains.
  assign pw = p_we && (p_wR != 5'd0) && !core_stall;

  // Secondary entries are never offered while reset is asserted, so a flush
  // cannot leak a queued result into the RF on the reset edge.
  assign grant_head = !pw && head_valid && !cpu_rst;

  // A killed head carries no write and is discarded whenever it is at the head.
  assign pop = !empty && (!ent_valid[rd_ptr] || !pw);

  assign push       = s_valid && s_ready;
  assign push_valid = (s_wR != 5'd0) && !(pw && (s_wR == p_wR));

  always_comb begin
    rf_we = 1'b0;
    rf_wR = '0;
    rf_wD = '0;
    if (pw) begin
      rf_we = 1'b1;
      rf_wR = p_wR;
      rf_wD = p_wD;
    end else if (grant_head) begin
      rf_we = 1'b1;
      rf_wR = ent_wr[rd_ptr];
      rf_wD = ent_wd[rd_ptr];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy_mask[ent_wr[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // Valid bits only hold for occupied slots: pop clears the slot, and push
  // never targets an occupied slot because it requires !full.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_valid[i] <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sc     <= '0;
    end else begin
      if (pw) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (ent_wr[i] == p_wR) ent_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + AW'(1);
      end
      if (push) begin
        ent_valid[wr_ptr] <= push_valid;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);

      if (empty || pop)
        sc <= '0;
      else if (head_valid && pw && (sc < SCW'(STARVE_LIMIT)))
        sc <= sc + SCW'(1);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      ent_wr[wr_ptr] <= s_wR;
      ent_wd[wr_ptr] <= s_wD;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched
//   Directed scenarios followed by random traffic, each cycle compared
//   against a queue-based reference model of the write-port scheduler.
module tb_rf_wb_sched;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        p_we;
  logic [4:0]  p_wR;
  logic [31:0] p_wD;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_wR;
  logic [31:0] s_wD;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic [31:0] busy_mask;
  logic        core_stall;

  rf_wb_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .p_we       (p_we),
    .p_wR       (p_wR),
    .p_wD       (p_wD),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_wR       (s_wR),
    .s_wD       (s_wD),
    .rf_we      (rf_we),
    .rf_wR      (rf_wR),
    .rf_wD      (rf_wD),
    .busy_mask  (busy_mask),
    .core_stall (core_stall)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    bit        v;
    bit [4:0]  r;
    bit [31:0] d;
  } ent_t;

  ent_t q[$];
  int   m_sc;
  int   checks;
  int   failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, compares outputs with the model, then
  // advances the model to the state after the coming rising edge.
  task automatic step(input bit rst, input bit pwe, input bit [4:0] pwr,
                      input bit [31:0] pwd, input bit sv, input bit [4:0] swr,
                      input bit [31:0] swd);
    bit        stall, pw, acc, popping;
    bit        e_we;
    bit [4:0]  e_wr;
    bit [31:0] e_wd, e_busy;
    @(negedge cpu_clk);
    cpu_rst = rst; p_we = pwe; p_wR = pwr; p_wD = pwd;
    s_valid = sv; s_wR = swr; s_wD = swd;
    #1;
    stall = (m_sc >= LIMIT);
    pw    = pwe && (pwr != 0) && !stall;
    e_we = 0; e_wr = 0; e_wd = 0;
    if (pw) begin
      e_we = 1; e_wr = pwr; e_wd = pwd;
    end else if (!rst && q.size() > 0 && q[0].v) begin
      e_we = 1; e_wr = q[0].r; e_wd = q[0].d;
    end
    e_busy = 0;
    foreach (q[i]) if (q[i].v && q[i].r != 0) e_busy[q[i].r] = 1'b1;
    chk("s_ready",    32'(s_ready),    32'(q.size() < DEPTH));
    chk("rf_we",      32'(rf_we),      32'(e_we));
    chk("rf_wR",      32'(rf_wR),      32'(e_wr));
    chk("rf_wD",      rf_wD,           e_wd);
    chk("busy_mask",  busy_mask,       e_busy);
    chk("core_stall", 32'(core_stall), 32'(stall));
    if (rst) begin
      q.delete();
      m_sc = 0;
    end else begin
      acc     = sv && (q.size() < DEPTH);
      popping = (q.size() > 0) && (!q[0].v || !pw);
      if (q.size() == 0 || popping) m_sc = 0;
      else if (q[0].v && pw) m_sc++;
      if (popping) void'(q.pop_front());
      if (pw) foreach (q[i]) if (q[i].r == pwr) q[i].v = 0;
      if (acc) q.push_back('{(swr != 0) && !(pw && swr == pwr), swr, swd});
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_sc = 0;
    cpu_rst = 1; p_we = 0; p_wR = 0; p_wD = 0; s_valid = 0; s_wR = 0; s_wD = 0;
    repeat (2) @(posedge cpu_clk);

    // Reset state then idle.
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_busy",    busy_mask,    32'd0);

    // Single secondary write to x5.
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("sec_we",   32'(rf_we), 32'd1);
    chk("sec_wR",   32'(rf_wR), 32'd5);
    chk("sec_wD",   rf_wD,      32'hDEADBEEF);
    chk("sec_busy", busy_mask,  32'h20);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("sec_busy_clr", busy_mask, 32'd0);

    // Starvation: x3, x4 queued while the primary writes every cycle.
    step(0, 1, 1, 32'hA1, 1, 3, 32'h33);
    step(0, 1, 2, 32'hA2, 1, 4, 32'h44);
    step(0, 1, 1, 32'hA3, 0, 0, 0);
    chk("full_ready", 32'(s_ready), 32'd0);
    step(0, 1, 2, 32'hA4, 0, 0, 0);
    step(0, 1, 1, 32'hA5, 0, 0, 0);
    step(0, 1, 2, 32'hA6, 0, 0, 0);
    chk("stall_on",  32'(core_stall), 32'd1);
    chk("stall_wR",  32'(rf_wR),      32'd3);
    step(0, 1, 1, 32'hA7, 0, 0, 0);
    chk("stall_off", 32'(core_stall), 32'd0);
    chk("prim_back", 32'(rf_wR),      32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain_x4",  32'(rf_wR),      32'd4);

    // Kill: x7 queued, primary writes x7 next cycle.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 32'h77);
    step(0, 1, 7, 32'h11, 0, 0, 0);
    chk("kill_wD", rf_wD, 32'h11);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("kill_busy", busy_mask,   32'd0);
    chk("kill_nowr", 32'(rf_we),  32'd0);

    // Same-cycle conflict on x9.
    step(0, 1, 9, 32'h99, 1, 9, 32'h55);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("conf_we",   32'(rf_we), 32'd0);
    chk("conf_busy", busy_mask,  32'd0);

    // x0 from both sources.
    step(0, 1, 0, 32'h1234, 1, 0, 32'h5678);
    chk("x0_prim", 32'(rf_we), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("x0_sec",  32'(rf_we), 32'd0);

    // Reset with two valid entries queued.
    step(0, 1, 1, 32'hB1, 1, 10, 32'hC1);
    step(0, 1, 2, 32'hB2, 1, 11, 32'hC2);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rstq_we", 32'(rf_we), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rstq_ready", 32'(s_ready), 32'd1);
    chk("rstq_busy",  busy_mask,    32'd0);
    chk("rstq_nowr",  32'(rf_we),   32'd0);

    // Random traffic with a narrow register range to provoke kills.
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0,
           5'($urandom_range(0, 7)), $urandom,
           ($urandom % 2) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-port scheduler for the register file in the single-cycle core. It shares the one RF write port (rf_we/rf_wR/rf_wD) between the core's writeback path (the output of the writeback-select mux) and a secondary long-latency result source, such as a multi-cycle multiply/divide unit. Secondary results are buffered in a small FIFO and drained into idle write cycles. The block also publishes a pending-write busy mask so the core can stall reads, and forces a core stall when the FIFO is starved.

## Interface
- DEPTH, default 2: secondary FIFO entries; power of two, at least 2.
- STARVE_LIMIT, default 4: consecutive cycles a non-empty FIFO may lose the port before core_stall is forced; at least 1.

Ports:
- cpu_clk  input  1  core clock; all state updates on the rising edge.
- cpu_rst  input  1  synchronous, active-high reset.
- p_we  input  1  primary (core writeback) write enable.
- p_wR  input  5  primary destination register.
- p_wD  input  32  primary write data (writeback mux output wD).
- s_valid  input  1  secondary result valid.
- s_ready  output  1  FIFO can accept; equals !full.
- s_wR  input  5  secondary destination register.
- s_wD  input  32  secondary write data.
- rf_we  output  1  RF write enable.
- rf_wR  output  5  RF write address.
- rf_wD  output  32  RF write data.
- busy_mask  output  32  bit r = a valid FIFO entry targets x_r; bit 0 is always 0.
- core_stall  output  1  core must freeze; p_we must be 0 while it is asserted.

## Operation
- Effective primary write: pw = p_we && p_wR != 0. Writes to x0 are discarded everywhere.
- Port grant, combinational:
  - pw=1: rf_* = primary.
  - Otherwise, if the FIFO head is valid: rf_* = head, and the head pops at the edge.
  - Otherwise rf_we=0, rf_wR=0, rf_wD=0.
- A killed (invalid) head pops in any cycle with no write, even when pw=1.
- Enqueue on s_valid && s_ready at the edge. An entry stores {valid, wR, wD}. An entry with s_wR=0 enqueues with valid=0.
- Kill rule: a primary write is program-order younger than every secondary result.
  - When pw=1, every FIFO entry whose wR equals p_wR has its valid bit cleared at the edge.
  - An entry being enqueued in the same cycle with the same register also enqueues invalid.
  - The handshake still completes in both cases.
- Simultaneous enqueue and pop are allowed. While full, a pop in a cycle frees a slot only for the next cycle, because s_ready is registered-state based: !full from the current count.
- Pointers wrap modulo DEPTH. An occupancy counter has width clog2(DEPTH)+1.
- busy_mask is the OR of the one-hot decode of all valid entries. It is derived from current state, not from the inputs.
- Starvation counter sc:
  - Increments when the FIFO holds a valid head and pw=1.
  - Clears on any head pop, and when the FIFO is empty.
  - core_stall = (sc >= STARVE_LIMIT), combinational from the register.
  - While core_stall=1, pw is treated as 0 even if p_we=1, so the head drains.
- Reset values: FIFO empty, all valid bits 0, sc=0. Therefore s_ready=1, rf_we=0, rf_wR=0, rf_wD=0, busy_mask=0, core_stall=0.
- Reset asserted mid-operation flushes all pending entries without writing them.

## Timing
- Secondary latency: an entry accepted at edge N is writable in cycle N+1 at the earliest. Its RF write commits at the edge ending that cycle.
- The primary path has zero added latency: rf_* follow p_* combinationally in the same cycle.
- busy_mask sets in the cycle after acceptance. It clears in the cycle after the pop or kill.
- core_stall asserts in the cycle after sc reaches STARVE_LIMIT. It holds for exactly the cycle(s) until the head pops, normally 1 cycle.
- Throughput: one RF write per cycle, and one secondary accept per cycle while not full.

## Test plan
- Reset, then idle: s_ready=1, rf_we=0, busy_mask=0, core_stall=0.
- Secondary s_wR=5, s_wD=0xDEADBEEF accepted at cycle 0 with no primary traffic:
  - cycle 1: rf_we=1, rf_wR=5, rf_wD=0xDEADBEEF, busy_mask=0x20.
  - cycle 2: busy_mask=0.
- Back-to-back secondary writes to x3 and x4 while the primary writes every cycle:
  - after the second accept, s_ready=0.
  - after 4 lost cycles, core_stall=1 and rf_wR=3.
  - then sc clears, core_stall=0, and x4 drains at the next free cycle.
- Kill: secondary x7 is queued, then primary writes x7=0x11:
  - the RF sees only x7=0x11.
  - busy_mask bit 7 clears the next cycle.
  - no later secondary write to x7 occurs.
- Same-cycle conflict: s_valid with x9 while the primary writes x9. The handshake completes, the entry never writes, and busy_mask bit 9 never sets.
- x0 and reset cases:
  - primary and secondary writes to x0 never produce rf_we=1.
  - asserting cpu_rst with 2 entries queued leaves the FIFO empty on the next cycle and produces no RF write.
